aes_key_expander: RTL and testbench

- Sequential, word-serial AES key schedule engine. Supports AES-128, AES-192 and AES-256, selected per key load.
- Generalises the single-round, AES-128-only combinational round-key step. It produces the complete round-key sequence, one 32-bit word per cycle.
- Emits 128-bit round keys over a valid/ready stream to the cipher datapath or a round-key store.
- Generates Rcon internally, so no per-round Rcon input is needed.

---
 rtl/aes_key_expander_if.sv | 22 ++
 rtl/aes_key_expander.sv | 158 +++++++++++++++
 tb/tb_aes_key_expander.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expander_if.sv
// aes_key_expander_if: key-load request and round-key output stream of the AES key expander.
interface aes_key_expander_if #(parameter int ROUND_W = 4);
  logic [255:0]       key_in;
  logic [1:0]         key_len;
  logic               key_valid;
  logic               key_ready;
  logic               abort;
  logic [127:0]       out_key;
  logic [ROUND_W-1:0] out_round;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;
  logic               cfg_err;
  modport master (
    output key_in, key_len, key_valid, abort, out_ready,
    input  key_ready, out_key, out_round, out_last, out_valid, cfg_err
  );
  modport slave (
    input  key_in, key_len, key_valid, abort, out_ready,
    output key_ready, out_key, out_round, out_last, out_valid, cfg_err
  );
endinterface

// File: rtl/aes_key_expander.sv
// aes_key_expander: word-serial AES-128/192/256 key schedule, one word per cycle, 128-bit round keys out.
module aes_key_expander_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  logic [7:0] sq, inv;
  // multiplicative inverse as a^254, then the affine transform
  always_comb begin
    sq  = a_i;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_key_expander #(
  parameter bit SUPPORT_192 = 1'b1,
  parameter bit SUPPORT_256 = 1'b1,
  parameter int ROUND_W     = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  aes_key_expander_if.slave   kif
);
  typedef enum logic [1:0] {IDLE, EXPAND, DRAIN} state_t;
  state_t             state_q, state_d;
  logic [255:0]       key_q, key_d;
  logic [1:0]         mode_q, mode_d;
  logic [5:0]         i_q, i_d;
  logic [2:0]         ph_q, ph_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [7:0][31:0]   win_q, win_d;
  logic [127:0]       out_key_q, out_key_d;
  logic [ROUND_W-1:0] out_round_q, out_round_d;
  logic               out_last_q, out_last_d;
  logic               out_valid_q, out_valid_d;
  logic               cfg_err_q, cfg_err_d;
  logic [2:0]         nk_m1;
  logic [3:0]         nr;
  logic [5:0]         total_m1;
  logic               first, legal, adv, rot_en;
  logic [31:0]        w_prev, w_back, key_word, sub_in, sub_out, temp, new_w;
  assign nk_m1    = mode_q == 2'b00 ? 3'd3 : mode_q == 2'b01 ? 3'd5 : 3'd7;
  assign nr       = mode_q == 2'b00 ? 4'd10 : mode_q == 2'b01 ? 4'd12 : 4'd14;
  assign total_m1 = mode_q == 2'b00 ? 6'd43 : mode_q == 2'b01 ? 6'd51 : 6'd59;
  assign first    = i_q <= {3'b000, nk_m1};
  assign legal    = kif.key_len == 2'b00 || (kif.key_len == 2'b01 && SUPPORT_192) || (kif.key_len == 2'b10 && SUPPORT_256);
  assign adv      = state_q == EXPAND && !(out_valid_q && !kif.out_ready);
  assign w_prev   = win_q[0];
  assign w_back   = win_q[nk_m1];
  // while i < Nk the phase counter equals i, so it doubles as the key word index
  assign key_word = key_q[{3'd7 - ph_q, 5'd0} +: 32];
  assign rot_en   = ph_q == 3'd0;
  assign sub_in   = rot_en ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_key_expander_sbox u_sbox (.a_i(sub_in[8*g +: 8]), .s_o(sub_out[8*g +: 8]));
  end
  assign temp  = rot_en ? sub_out ^ {rcon_q, 24'h0} : (mode_q == 2'b10 && ph_q == 3'd4) ? sub_out : w_prev;
  assign new_w = first ? key_word : w_back ^ temp;
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    mode_d      = mode_q;
    i_d         = i_q;
    ph_d        = ph_q;
    rcon_d      = rcon_q;
    win_d       = win_q;
    out_key_d   = out_key_q;
    out_round_d = out_round_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !kif.out_ready;
    cfg_err_d   = 1'b0;
    if (kif.abort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      i_d         = '0;
      ph_d        = '0;
      rcon_d      = 8'h01;
      win_d       = '0;
    end else if (state_q == IDLE) begin
      if (kif.key_valid && legal) begin
        state_d = EXPAND;
        key_d   = kif.key_in;
        mode_d  = kif.key_len;
        i_d     = '0;
        ph_d    = '0;
        rcon_d  = 8'h01;
        win_d   = '0;
      end
      cfg_err_d = kif.key_valid && !legal;
    end else if (state_q == EXPAND) begin
      if (adv) begin
        win_d  = {win_q[6:0], new_w};
        i_d    = i_q + 6'd1;
        ph_d   = ph_q == nk_m1 ? 3'd0 : ph_q + 3'd1;
        rcon_d = (!first && rot_en) ? ({rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00)) : rcon_q;
        state_d = i_q == total_m1 ? DRAIN : EXPAND;
        // the window already holds the three preceding words of this round key
        if (i_q[1:0] == 2'b11) begin
          out_key_d   = {win_q[2], win_q[1], w_prev, new_w};
          out_round_d = ROUND_W'(i_q[5:2]);
          out_last_d  = i_q[5:2] == nr;
          out_valid_d = 1'b1;
        end
      end
    end else begin
      state_d = (out_valid_q && kif.out_ready && out_last_q) ? IDLE : DRAIN;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      key_q       <= '0;
      mode_q      <= '0;
      i_q         <= '0;
      ph_q        <= '0;
      rcon_q      <= 8'h01;
      win_q       <= '0;
      out_key_q   <= '0;
      out_round_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      i_q         <= i_d;
      ph_q        <= ph_d;
      rcon_q      <= rcon_d;
      win_q       <= win_d;
      out_key_q   <= out_key_d;
      out_round_q <= out_round_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end
  assign kif.key_ready = state_q == IDLE;
  assign kif.out_key   = out_key_q;
  assign kif.out_round = out_round_q;
  assign kif.out_last  = out_last_q;
  assign kif.out_valid = out_valid_q;
  assign kif.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: directed FIPS-197 vectors, backpressure, illegal modes, abort and reset.
module tb_aes_key_expander;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  aes_key_expander_if kif ();
  aes_key_expander_if kif2 ();
  aes_key_expander dut (.clk(clk), .reset_n(reset_n), .kif(kif));
  aes_key_expander #(.SUPPORT_192(1'b0)) dut2 (.clk(clk), .reset_n(reset_n), .kif(kif2));
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] T128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  bit rand_rdy = 1'b0;
  logic [127:0] cap_key [$];
  int cap_round [$];
  bit cap_last [$];
  int cap_cyc [$];
  logic [127:0] p_key;
  int p_round;
  bit p_stall = 1'b0;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    kif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 kif.out_ready = rand_rdy ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
  end
  always @(negedge clk) begin
    if (!reset_n) p_stall <= 1'b0;
    else begin
      if (p_stall) begin
        check("stall_valid", kif.out_valid, 1);
        check("stall_key", kif.out_key, p_key);
        check("stall_round", kif.out_round, p_round);
      end
      if (kif.out_valid && kif.out_ready) begin
        cap_key.push_back(kif.out_key);
        cap_round.push_back(int'(kif.out_round));
        cap_last.push_back(kif.out_last);
        cap_cyc.push_back(cyc);
      end
      p_stall <= kif.out_valid && !kif.out_ready;
      p_key   <= kif.out_key;
      p_round <= int'(kif.out_round);
    end
  end
  task automatic clear_caps();
    cap_key.delete();
    cap_round.delete();
    cap_last.delete();
    cap_cyc.delete();
  endtask
  task automatic load(input logic [255:0] k, input logic [1:0] len, output int c0);
    @(negedge clk);
    check("load_ready", kif.key_ready, 1);
    kif.key_in = k;
    kif.key_len = len;
    kif.key_valid = 1'b1;
    c0 = cyc;
    @(negedge clk);
    kif.key_valid = 1'b0;
    check("load_busy", kif.key_ready, 0);
  endtask
  task automatic wait_done(input string tag, input int n);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (cap_key.size() >= n && kif.key_ready) break;
    end
    check({tag, "_count"}, cap_key.size(), n);
    check({tag, "_idle"}, kif.key_ready, 1);
  endtask
  task automatic verify128(input string tag);
    if (cap_key.size() == 11)
      for (int j = 0; j < 11; j++) begin
        check($sformatf("%s_key%0d", tag, j), cap_key[j], T128[j]);
        check($sformatf("%s_rnd%0d", tag, j), cap_round[j], j);
        check($sformatf("%s_last%0d", tag, j), cap_last[j], j == 10);
      end
  endtask
  task automatic verify(input string tag, input int n, input logic [127:0] r0, input logic [127:0] r1, input logic [127:0] rl);
    if (cap_key.size() == n) begin
      check({tag, "_r0"}, cap_key[0], r0);
      check({tag, "_r1"}, cap_key[1], r1);
      check({tag, "_rlast"}, cap_key[n-1], rl);
      check({tag, "_last"}, cap_last[n-1], 1);
      check({tag, "_notlast"}, cap_last[n-2], 0);
      for (int j = 0; j < n; j++) check($sformatf("%s_rnd%0d", tag, j), cap_round[j], j);
    end
  endtask
  initial begin
    int c0;
    bit found;
    kif.key_in = '0;
    kif.key_len = 2'b00;
    kif.key_valid = 1'b0;
    kif.abort = 1'b0;
    kif2.key_in = '0;
    kif2.key_len = 2'b00;
    kif2.key_valid = 1'b0;
    kif2.abort = 1'b0;
    kif2.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_key_ready", kif.key_ready, 1);
    check("rst_valid", kif.out_valid, 0);
    check("rst_last", kif.out_last, 0);
    check("rst_cfg_err", kif.cfg_err, 0);
    check("rst_key", kif.out_key, 0);
    check("rst_round", kif.out_round, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_caps();
    load(K128, 2'b00, c0);
    wait_done("a128", 11);
    verify128("a128");
    if (cap_cyc.size() == 11) check("a128_latency", cap_cyc[10] - c0, 45);
    clear_caps();
    load(K192, 2'b01, c0);
    wait_done("a192", 13);
    verify("a192", 13, 128'h8e73b0f7da0e6452c810f32b809079e5, 128'h62f8ead2522c6b7bfe0c91f72402f5a5,
           128'he98ba06f448c773c8ecc720401002202);
    clear_caps();
    load(K256, 2'b10, c0);
    wait_done("a256", 15);
    verify("a256", 15, 128'h603deb1015ca71be2b73aef0857d7781, 128'h1f352c073b6108d72d9810a30914dff4,
           128'hfe4890d1e6188d0b046df344706c631e);
    clear_caps();
    rand_rdy = 1'b1;
    load(K128, 2'b00, c0);
    wait_done("stall", 11);
    rand_rdy = 1'b0;
    verify128("stall");
    repeat (2) @(negedge clk);
    clear_caps();
    kif.key_len = 2'b11;
    kif.key_valid = 1'b1;
    @(negedge clk);
    kif.key_valid = 1'b0;
    check("ill_cfg_err", kif.cfg_err, 1);
    check("ill_ready", kif.key_ready, 1);
    @(negedge clk);
    check("ill_cfg_err_clr", kif.cfg_err, 0);
    kif2.key_len = 2'b01;
    kif2.key_in = K192;
    kif2.key_valid = 1'b1;
    @(negedge clk);
    kif2.key_valid = 1'b0;
    check("dis192_cfg_err", kif2.cfg_err, 1);
    check("dis192_ready", kif2.key_ready, 1);
    @(negedge clk);
    check("dis192_cfg_err_clr", kif2.cfg_err, 0);
    check("dis192_no_out", kif2.out_valid, 0);
    kif2.key_len = 2'b00;
    kif2.key_in = K128;
    kif2.key_valid = 1'b1;
    @(negedge clk);
    kif2.key_valid = 1'b0;
    check("en128_accept", kif2.key_ready, 0);
    check("en128_cfg_err", kif2.cfg_err, 0);
    repeat (8) @(negedge clk);
    check("ill_no_out", cap_key.size(), 0);
    load(K256, 2'b10, c0);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (kif.out_valid && kif.out_round == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reach_r5", found, 1);
    kif.abort = 1'b1;
    @(negedge clk);
    kif.abort = 1'b0;
    check("abort_valid", kif.out_valid, 0);
    check("abort_idle", kif.key_ready, 1);
    kif.abort = 1'b1;
    kif.key_in = K128;
    kif.key_len = 2'b00;
    kif.key_valid = 1'b1;
    @(negedge clk);
    kif.abort = 1'b0;
    kif.key_valid = 1'b0;
    check("abort_prio", kif.key_ready, 1);
    clear_caps();
    load(K128, 2'b00, c0);
    wait_done("post_abort", 11);
    verify128("post_abort");
    clear_caps();
    load(K128, 2'b00, c0);
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", kif.out_valid, 0);
    check("arst_key", kif.out_key, 0);
    check("arst_round", kif.out_round, 0);
    check("arst_last", kif.out_last, 0);
    check("arst_ready", kif.key_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_caps();
    load(K128, 2'b00, c0);
    wait_done("post_rst", 11);
    verify128("post_rst");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
